// File: rtl/vlin_pkg.sv
// Shared types and helpers for the vlin matrix-vector engine.
// Narrowing mode is selected by the VLIN_SAT_EN macro: defined -> saturate,
// undefined -> two's-complement wrap to the low DATA_W bits.
package vlin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_e;

    // Wide enough to carry any accumulator the engine can be configured for.
    localparam int SAT_IN_W = 256;

    function automatic int acc_width(input int data_w, input int vec_len);
        return 2 * data_w + $clog2(vec_len);
    endfunction

    function automatic int pipe_latency(input int vec_len);
        return 3 + $clog2(vec_len);
    endfunction

    // Narrows val to data_w bits; the result comes back sign-extended so the
    // caller only has to keep the low data_w bits.
    function automatic logic signed [SAT_IN_W-1:0] sat_narrow(
        input logic signed [SAT_IN_W-1:0] val,
        input int                         data_w
    );
        logic signed [SAT_IN_W-1:0] res;
`ifdef VLIN_SAT_EN
        logic signed [SAT_IN_W-1:0] max_v;
        logic signed [SAT_IN_W-1:0] min_v;
        max_v = (SAT_IN_W'(1) <<< (data_w - 1)) - SAT_IN_W'(1);
        min_v = ~max_v;
        if (val > max_v) begin
            res = max_v;
        end else if (val < min_v) begin
            res = min_v;
        end else begin
            res = val;
        end
`else
        res = (val <<< (SAT_IN_W - data_w)) >>> (SAT_IN_W - data_w);
`endif
        return res;
    endfunction

endpackage

// File: rtl/vlin_matvec_engine_if.sv
// Job control, weight-memory and result-stream signals of the vlin engine.
// slave = engine side, master = job issuer / memory / result consumer side.
interface vlin_matvec_engine_if #(
    parameter int DATA_W  = 32,
    parameter int VEC_LEN = 32,
    parameter int N_LANES = 2,
    parameter int N_ROWS  = 96,
    parameter int ADDR_W  = $clog2(N_ROWS),
    parameter int GRP_W   = $clog2(N_ROWS / N_LANES) + 1
);

    logic                                     start;
    logic [ADDR_W-1:0]                        row_base;
    logic [GRP_W-1:0]                         num_groups;
    logic [VEC_LEN-1:0][DATA_W-1:0]           vec_in;
    logic                                     busy;
    logic                                     done;
    logic                                     mem_rd_en;
    logic [ADDR_W-1:0]                        mem_row;
    logic [N_LANES-1:0][VEC_LEN-1:0][DATA_W-1:0] wt_rdata;
    logic [N_LANES-1:0][DATA_W-1:0]           bias_rdata;
    logic                                     out_valid;
    logic [ADDR_W-1:0]                        out_row;
    logic [N_LANES-1:0][DATA_W-1:0]           out_data;

    modport slave (
        input  start, row_base, num_groups, vec_in, wt_rdata, bias_rdata,
        output busy, done, mem_rd_en, mem_row, out_valid, out_row, out_data
    );

    modport master (
        output start, row_base, num_groups, vec_in, wt_rdata, bias_rdata,
        input  busy, done, mem_rd_en, mem_row, out_valid, out_row, out_data
    );

endinterface

// File: rtl/vlin_dot_lane.sv
// One row of the matrix-vector product: registered products, registered
// adder tree, then bias add, Q-format rescale and narrowing in a final register.
// Narrowing follows VLIN_SAT_EN through vlin_pkg::sat_narrow.
module vlin_dot_lane
    import vlin_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int VEC_LEN = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [VEC_LEN-1:0][DATA_W-1:0] x,
    input  logic [VEC_LEN-1:0][DATA_W-1:0] w,
    input  logic [DATA_W-1:0]              bias,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data
);

    localparam int LEVELS = $clog2(VEC_LEN);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, VEC_LEN);
    localparam int HALF   = VEC_LEN / 2;

    logic signed [PROD_W-1:0] prod_d [VEC_LEN];
    logic signed [PROD_W-1:0] prod_q [VEC_LEN];
    logic signed [ACC_W-1:0]  sum_d  [LEVELS][HALF];
    logic signed [ACC_W-1:0]  sum_q  [LEVELS][HALF];
    logic signed [DATA_W-1:0] bias_d [LEVELS+1];
    logic signed [DATA_W-1:0] bias_q [LEVELS+1];
    logic [LEVELS+1:0]        vld_d;
    logic [LEVELS+1:0]        vld_q;
    logic [DATA_W-1:0]        out_data_d;
    logic [DATA_W-1:0]        out_data_q;
    logic signed [ACC_W-1:0]  acc_total;
    logic signed [ACC_W-1:0]  acc_scaled;

    // Full-width signed products; bias rides along so it meets the tree root.
    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            prod_d[i] = PROD_W'($signed(x[i])) * PROD_W'($signed(w[i]));
        end
        bias_d[0] = $signed(bias);
        for (int l = 0; l < LEVELS; l++) begin
            bias_d[l+1] = bias_q[l];
        end
    end

    // Pairwise adder tree, one register per level; level l keeps VEC_LEN>>(l+1) sums.
    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < HALF; i++) begin
                sum_d[l][i] = '0;
            end
        end
        for (int i = 0; i < HALF; i++) begin
            sum_d[0][i] = ACC_W'(prod_q[2*i]) + ACC_W'(prod_q[2*i+1]);
        end
        for (int l = 1; l < LEVELS; l++) begin
            for (int i = 0; i < (VEC_LEN >> (l + 1)); i++) begin
                sum_d[l][i] = sum_q[l-1][2*i] + sum_q[l-1][2*i+1];
            end
        end
    end

    // Bias is aligned to the product scale, then the sum is floored back to Q format.
    always_comb begin
        acc_total  = sum_q[LEVELS-1][0] + (ACC_W'(bias_q[LEVELS]) <<< FRAC_W);
        acc_scaled = acc_total >>> FRAC_W;
        out_data_d = out_data_q;
        if (vld_q[LEVELS]) begin
            out_data_d = DATA_W'(sat_narrow(SAT_IN_W'(acc_scaled), DATA_W));
        end
        vld_d = {vld_q[LEVELS:0], in_valid};
    end

    // Datapath registers need no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
        bias_q <= bias_d;
    end

    // Valid chain and result register clear on reset so nothing stale escapes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q      <= '0;
            out_data_q <= '0;
        end else begin
            vld_q      <= vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = vld_q[LEVELS+1];
    assign out_data  = out_data_q;

endmodule

// File: rtl/vlin_matvec_engine.sv
// N_LANES-wide matrix-vector engine y[r] = W[r,:].x + b[r] with a row-tagged result stream.
// Jobs cover num_groups groups of N_LANES rows starting at row_base; one group is issued per cycle.
// Define VLIN_SAT_EN to saturate results instead of wrapping them to DATA_W bits.
module vlin_matvec_engine
    import vlin_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int VEC_LEN = 32,
    parameter int N_LANES = 2,
    parameter int N_ROWS  = 96,
    parameter int ADDR_W  = $clog2(N_ROWS),
    parameter int GRP_W   = $clog2(N_ROWS / N_LANES) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vlin_matvec_engine_if.slave    bus
);

    localparam int LAT = pipe_latency(VEC_LEN);

    state_e                         state_q, state_d;
    logic [GRP_W-1:0]               grp_cnt_q, grp_cnt_d;
    logic [GRP_W-1:0]               num_groups_q, num_groups_d;
    logic [ADDR_W-1:0]              row_base_q, row_base_d;
    logic [VEC_LEN-1:0][DATA_W-1:0] x_q, x_d;
    logic [LAT-2:0]                 tag_vld_q, tag_vld_d;
    logic [LAT-1:0][ADDR_W-1:0]     tag_row_q, tag_row_d;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_row;
    logic [ADDR_W-1:0]              issue_row;
    logic [N_LANES-1:0]             lane_vld;
    logic [N_LANES-1:0][DATA_W-1:0] lane_data;

    assign issue_row = row_base_q + ADDR_W'(32'(grp_cnt_q) * N_LANES);

    // Job sequencing: accept, issue one group per cycle, drain the pipe, pulse done.
    always_comb begin
        state_d      = state_q;
        grp_cnt_d    = grp_cnt_q;
        num_groups_d = num_groups_q;
        row_base_d   = row_base_q;
        x_d          = x_q;
        rd_en        = 1'b0;
        rd_row       = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d          = bus.vec_in;
                    row_base_d   = bus.row_base;
                    num_groups_d = bus.num_groups;
                    grp_cnt_d    = '0;
                    state_d      = (bus.num_groups == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                rd_en     = 1'b1;
                rd_row    = issue_row;
                grp_cnt_d = grp_cnt_q + GRP_W'(1);
                if ((grp_cnt_q + GRP_W'(1)) == num_groups_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tag_vld_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row tags travel beside the lane pipelines; the valid bits tell DRAIN when it is empty.
    always_comb begin
        tag_vld_d = {tag_vld_q[LAT-3:0], rd_en};
        tag_row_d = {tag_row_q[LAT-2:0], rd_row};
    end

    // Control, job context and tag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grp_cnt_q    <= '0;
            num_groups_q <= '0;
            row_base_q   <= '0;
            x_q          <= '0;
            tag_vld_q    <= '0;
            tag_row_q    <= '0;
        end else begin
            state_q      <= state_d;
            grp_cnt_q    <= grp_cnt_d;
            num_groups_q <= num_groups_d;
            row_base_q   <= row_base_d;
            x_q          <= x_d;
            tag_vld_q    <= tag_vld_d;
            tag_row_q    <= tag_row_d;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        vlin_dot_lane #(
            .DATA_W  (DATA_W),
            .FRAC_W  (FRAC_W),
            .VEC_LEN (VEC_LEN)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (tag_vld_q[0]),
            .x         (x_q),
            .w         (bus.wt_rdata[k]),
            .bias      (bus.bias_rdata[k]),
            .out_valid (lane_vld[k]),
            .out_data  (lane_data[k])
        );
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_row   = rd_row;
    assign bus.out_valid = &lane_vld;
    assign bus.out_row   = tag_row_q[LAT-1];
    assign bus.out_data  = lane_data;

endmodule

// File: tb/tb_vlin_matvec_engine.sv
// Self-checking bench for vlin_matvec_engine: table of uniform-fill jobs with
// hand-computed Q16.16 results, plus latency, empty-job, busy-start and reset sequences.
module tb_vlin_matvec_engine;

    localparam int DATA_W  = 32;
    localparam int VEC_LEN = 32;
    localparam int N_LANES = 2;
    localparam int N_ROWS  = 96;
    localparam int LAT     = 8;

    typedef struct {
        logic [31:0] x_val;
        logic [31:0] w_val;
        logic [31:0] b_val;
        logic [31:0] b_step;
        logic [6:0]  row_base;
        logic [6:0]  groups;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int n_compared = 0;
    int n_failed   = 0;

    logic [31:0] cur_w = '0;
    logic [31:0] cur_b = '0;
    logic [31:0] cur_step = '0;
    logic [31:0] cur_exp = '0;

    logic [6:0] exp_rows[$];

    int beat_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int last_rd_cyc = 0;
    int last_valid_cyc = 0;
    int last_done_cyc = 0;

    vec_t vecs[6];

    vlin_matvec_engine_if #(
        .DATA_W  (DATA_W),
        .VEC_LEN (VEC_LEN),
        .N_LANES (N_LANES),
        .N_ROWS  (N_ROWS)
    ) bus ();

    vlin_matvec_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] rowPlus(input logic [6:0] r, input int k);
        return r + 7'(k);
    endfunction

    function automatic logic [31:0] expData(input logic [6:0] r);
        return cur_exp + cur_step * 32'(r);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_failed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Weight/bias memory: uniform weights, bias = b_val + row*b_step, one cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            for (int k = 0; k < N_LANES; k++) begin
                bus.wt_rdata[k]   <= {VEC_LEN{cur_w}};
                bus.bias_rdata[k] <= cur_b + cur_step * 32'(rowPlus(bus.mem_row, k));
            end
        end
    end

    // Result monitor: every beat must match the next expected row and its data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (bus.out_valid) begin
                beat_cnt++;
                last_valid_cyc = cyc;
                if (exp_rows.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    logic [6:0] r;
                    r = exp_rows.pop_front();
                    checkOutput("out_row", 64'(bus.out_row), 64'(r));
                    for (int k = 0; k < N_LANES; k++) begin
                        checkOutput("out_data", 64'(bus.out_data[k]), 64'(expData(rowPlus(r, k))));
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [6:0] rb, input logic [6:0] ng,
                                 input logic [31:0] xv, output int acc_cyc);
        for (int g = 0; g < int'(ng); g++) begin
            exp_rows.push_back(rowPlus(rb, 2 * g));
        end
        @(negedge clk);
        bus.start      = 1'b1;
        bus.row_base   = rb;
        bus.num_groups = ng;
        bus.vec_in     = {VEC_LEN{xv}};
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("busy_at_done", 64'(bus.busy), 64'd1);
        end
        #1;
    endtask

    task automatic runJob(input logic [6:0] rb, input logic [6:0] ng, input logic [31:0] xv,
                          input bit inject_start, output int acc_cyc);
        int b0, r0, d0;
        b0 = beat_cnt;
        r0 = rd_cnt;
        d0 = done_cnt;
        applyStimulus(rb, ng, xv, acc_cyc);
        checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
        checkOutput("rd_en_after_accept", 64'(bus.mem_rd_en), 64'(ng != 0));
        checkOutput("done_after_accept", 64'(bus.done), 64'(ng == 0));
        if (inject_start) begin
            repeat (2) @(negedge clk);
            bus.start      = 1'b1;
            bus.row_base   = 7'd64;
            bus.num_groups = 7'd1;
            bus.vec_in     = '0;
            @(negedge clk);
            bus.start = 1'b0;
        end
        waitDone();
        checkOutput("rd_count", 64'(rd_cnt - r0), 64'(ng));
        checkOutput("beat_count", 64'(beat_cnt - b0), 64'(ng));
        checkOutput("done_count", 64'(done_cnt - d0), 64'd1);
        checkOutput("rows_left", 64'(exp_rows.size()), 64'd0);
        if (ng != 0) begin
            checkOutput("done_after_last_beat", 64'(last_done_cyc - last_valid_cyc), 64'd1);
        end else begin
            checkOutput("empty_job_done_cycle", 64'(last_done_cyc), 64'(acc_cyc));
        end
        @(negedge clk);
        checkOutput("busy_cleared", 64'(bus.busy), 64'd0);
    endtask

    task automatic setVector(input vec_t v);
        cur_w    = v.w_val;
        cur_b    = v.b_val;
        cur_step = v.b_step;
`ifdef VLIN_SAT_EN
        cur_exp  = v.exp_sat;
`else
        cur_exp  = v.exp_wrap;
`endif
    endtask

    initial begin
        int acc_cyc;
        int b0, r0, d0;

        bus.start      = 1'b0;
        bus.row_base   = '0;
        bus.num_groups = '0;
        bus.vec_in     = '0;
        rst_n          = 1'b0;

        // x, w, b, b_step, row_base, groups, expected(wrap), expected(saturate)
        vecs[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0, 7'd0,   7'd48, 32'h0020_8000, 32'h0020_8000};
        vecs[1] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000, 7'd10, 7'd3, 32'hFFE0_0000, 32'hFFE0_0000};
        vecs[2] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 7'd4,   7'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h0, 7'd0,   7'd1,  32'h0020_0000, 32'h7FFF_FFFF};
        vecs[4] = '{32'h7FFF_0000, 32'h8000_0000, 32'h0000_0000, 32'h0, 7'd2,   7'd1,  32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{32'h0002_0000, 32'h0001_8000, 32'hFFFF_0000, 32'h0, 7'd126, 7'd2,  32'h005F_0000, 32'h005F_0000};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        checkOutput("rst_mem_row", 64'(bus.mem_row), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_row", 64'(bus.out_row), 64'd0);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            setVector(vecs[i]);
            runJob(vecs[i].row_base, vecs[i].groups, vecs[i].x_val, 1'b0, acc_cyc);
        end

        // Single group: first read the cycle after accept, result exactly LAT cycles later.
        setVector(vecs[0]);
        runJob(7'd32, 7'd1, 32'h0001_0000, 1'b0, acc_cyc);
        checkOutput("first_rd_cycle", 64'(last_rd_cyc), 64'(acc_cyc));
        checkOutput("latency", 64'(last_valid_cyc - last_rd_cyc), 64'(LAT));

        // Empty job: no reads, no beats, done straight away.
        runJob(7'd20, 7'd0, 32'h0001_0000, 1'b0, acc_cyc);

        // Start while busy must not spawn a second job or change rows.
        runJob(7'd0, 7'd4, 32'h0001_0000, 1'b1, acc_cyc);

        // Reset in the middle of a long job.
        b0 = beat_cnt;
        applyStimulus(7'd0, 7'd20, 32'h0001_0000, acc_cyc);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_done", 64'(bus.done), 64'd0);
        checkOutput("midrst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        checkOutput("midrst_mem_row", 64'(bus.mem_row), 64'd0);
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_out_row", 64'(bus.out_row), 64'd0);
        checkOutput("midrst_out_data", 64'(bus.out_data), 64'd0);
        exp_rows.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_cnt;
        d0 = done_cnt;
        b0 = beat_cnt;
        repeat (15) @(negedge clk);
        #1;
        checkOutput("post_rst_beats", 64'(beat_cnt - b0), 64'd0);
        checkOutput("post_rst_reads", 64'(rd_cnt - r0), 64'd0);
        checkOutput("post_rst_done", 64'(done_cnt - d0), 64'd0);
        runJob(7'd8, 7'd2, 32'h0001_0000, 1'b0, acc_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
